can_bit_destuffer: RTL and testbench

Parametrised CAN/CAN FD bit destuffer on the receive path, between the bit-timing sampler and the frame decoder. Consumes one sampled bus bit per `i_Sample` strobe. Removes dynamic stuff bits, or fixed-period stuff bits in CAN FD CRC mode, and forwards only data bits with a valid strobe. Flags stuff violations and counts removed dynamic stuff bits for the FD stuff-count field.

---
 rtl/can_bit_destuffer.sv | 145 ++++++++++++++
 tb/tb_can_bit_destuffer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/can_bit_destuffer.sv
// CAN / CAN FD receive-path bit destuffer: strips dynamic or fixed-period stuff bits,
// forwards data bits with a one-cycle valid strobe and flags stuff violations.
module can_bit_destuffer #(
    parameter int STUFF_LEN    = 5,
    parameter int FIXED_PERIOD = 4,
    parameter int CNT_W        = 3
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Sample,
    input  logic             i_Bit,
    input  logic             i_Enable,
    input  logic             i_Fixed,
    input  logic             i_Restart,
    output logic             o_Bit,
    output logic             o_Valid,
    output logic             o_Stuff,
    output logic             o_Err,
    output logic [CNT_W-1:0] o_Stuff_Cnt
);

    localparam int RUN_W = $clog2(STUFF_LEN + 1);
    localparam int FIX_W = $clog2(FIXED_PERIOD + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUFF_LEN);
    localparam logic [FIX_W-1:0] FIX_MAX = FIX_W'(FIXED_PERIOD);

    typedef enum logic [1:0] {
        OUT_NONE,
        OUT_DATA,
        OUT_STUFF,
        OUT_ERR
    } outcome_t;

    logic             last_bit;
    logic [RUN_W-1:0] run_cnt;
    logic [FIX_W-1:0] fix_cnt;
    logic             fixed_q;
    logic [CNT_W-1:0] stuff_cnt;

    logic             base_last;
    logic [RUN_W-1:0] base_run;
    logic [FIX_W-1:0] base_fix;
    logic             base_fixed_q;
    logic [CNT_W-1:0] base_cnt;

    logic             nxt_last;
    logic [RUN_W-1:0] nxt_run;
    logic [FIX_W-1:0] nxt_fix;
    logic             nxt_fixed_q;
    logic [CNT_W-1:0] nxt_cnt;
    outcome_t         outcome;

    // Restart is folded in ahead of the bit decision, so a coincident strobe is
    // judged against the cleared run state.
    always_comb begin
        base_last    = i_Restart ? 1'b1 : last_bit;
        base_run     = i_Restart ? '0 : run_cnt;
        base_fix     = i_Restart ? '0 : fix_cnt;
        base_fixed_q = i_Restart ? 1'b0 : fixed_q;
        base_cnt     = i_Restart ? '0 : stuff_cnt;
    end

    // NOTE: every output of this block gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        nxt_last    = base_last;
        nxt_run     = base_run;
        nxt_fix     = base_fix;
        nxt_fixed_q = base_fixed_q;
        nxt_cnt     = base_cnt;
        outcome     = OUT_NONE;

        if (i_Sample) begin
            nxt_last = i_Bit;
            if (!i_Enable) begin
                outcome     = OUT_DATA;
                nxt_run     = '0;
                nxt_fix     = '0;
                nxt_fixed_q = 1'b0;
            end else if (!i_Fixed) begin
                nxt_fixed_q = 1'b0;
                if (base_run == RUN_MAX) begin
                    if (i_Bit != base_last) begin
                        // The stuff bit itself opens the next run.
                        outcome = OUT_STUFF;
                        nxt_run = RUN_W'(1);
                        nxt_cnt = base_cnt + CNT_W'(1);
                    end else begin
                        outcome = OUT_ERR;
                        nxt_run = '0;
                    end
                end else begin
                    outcome = OUT_DATA;
                    if (i_Bit == base_last && base_run != '0) begin
                        nxt_run = base_run + RUN_W'(1);
                    end else begin
                        nxt_run = RUN_W'(1);
                    end
                end
            end else begin
                nxt_fixed_q = 1'b1;
                nxt_run     = '0;
                // The first fixed-mode strobe is always a fixed stuff bit.
                if (!base_fixed_q || base_fix == FIX_MAX) begin
                    outcome = (i_Bit != base_last) ? OUT_STUFF : OUT_ERR;
                    nxt_fix = '0;
                end else begin
                    outcome = OUT_DATA;
                    nxt_fix = base_fix + FIX_W'(1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            last_bit  <= 1'b1;
            run_cnt   <= '0;
            fix_cnt   <= '0;
            fixed_q   <= 1'b0;
            stuff_cnt <= '0;
            o_Bit     <= 1'b1;
            o_Valid   <= 1'b0;
            o_Stuff   <= 1'b0;
            o_Err     <= 1'b0;
        end else begin
            last_bit  <= nxt_last;
            run_cnt   <= nxt_run;
            fix_cnt   <= nxt_fix;
            fixed_q   <= nxt_fixed_q;
            stuff_cnt <= nxt_cnt;
            o_Valid   <= (outcome == OUT_DATA);
            o_Stuff   <= (outcome == OUT_STUFF);
            o_Err     <= (outcome == OUT_ERR);
            if (outcome == OUT_DATA) begin
                o_Bit <= i_Bit;
            end
        end
    end

    assign o_Stuff_Cnt = stuff_cnt;

endmodule

// File: tb/tb_can_bit_destuffer.sv
// Directed bench for can_bit_destuffer (default parameters): dynamic stuffing,
// stuff errors, fixed mode, counter wrap, bypass, restart and async reset.
module tb_can_bit_destuffer;

    localparam logic [1:0] K_NONE  = 2'd0;
    localparam logic [1:0] K_DATA  = 2'd1;
    localparam logic [1:0] K_STUFF = 2'd2;
    localparam logic [1:0] K_ERR   = 2'd3;

    logic       i_Clk = 1'b0;
    logic       i_Rst;
    logic       i_Sample;
    logic       i_Bit;
    logic       i_Enable;
    logic       i_Fixed;
    logic       i_Restart;
    logic       o_Bit;
    logic       o_Valid;
    logic       o_Stuff;
    logic       o_Err;
    logic [2:0] o_Stuff_Cnt;

    int n_asserts = 0;
    int n_fail    = 0;

    can_bit_destuffer #(
        .STUFF_LEN   (5),
        .FIXED_PERIOD(4),
        .CNT_W       (3)
    ) dut (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_Sample   (i_Sample),
        .i_Bit      (i_Bit),
        .i_Enable   (i_Enable),
        .i_Fixed    (i_Fixed),
        .i_Restart  (i_Restart),
        .o_Bit      (o_Bit),
        .o_Valid    (o_Valid),
        .o_Stuff    (o_Stuff),
        .o_Err      (o_Err),
        .o_Stuff_Cnt(o_Stuff_Cnt)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flags are {valid, stuff, err}; o_Bit is only meaningful on data outcomes.
    task automatic expect_out(input string tag, input logic [1:0] kind, input logic b,
                              input logic [2:0] cnt);
        logic [2:0] exp_flags;
        case (kind)
            K_DATA:  exp_flags = 3'b100;
            K_STUFF: exp_flags = 3'b010;
            K_ERR:   exp_flags = 3'b001;
            default: exp_flags = 3'b000;
        endcase
        chk({tag, " flags"}, {13'b0, o_Valid, o_Stuff, o_Err}, {13'b0, exp_flags});
        if (kind == K_DATA) chk({tag, " bit"}, 16'(o_Bit), 16'(b));
        chk({tag, " cnt"}, 16'(o_Stuff_Cnt), 16'(cnt));
    endtask

    // One strobe; returns #1 after the edge, where the registered response is visible.
    task automatic send(input logic b);
        i_Bit    = b;
        i_Sample = 1'b1;
        @(posedge i_Clk);
        #1;
        i_Sample = 1'b0;
    endtask

    task automatic restart_only();
        i_Restart = 1'b1;
        @(posedge i_Clk);
        #1;
        i_Restart = 1'b0;
    endtask

    initial begin
        i_Rst     = 1'b1;
        i_Sample  = 1'b0;
        i_Bit     = 1'b0;
        i_Enable  = 1'b1;
        i_Fixed   = 1'b0;
        i_Restart = 1'b0;
        repeat (2) @(posedge i_Clk);
        #1;
        expect_out("reset", K_NONE, 1'b0, 3'd0);
        chk("reset bit", 16'(o_Bit), 16'd1);
        i_Rst = 1'b0;
        @(posedge i_Clk);
        #1;

        // Dynamic stuffing: 5 zeros, stuff 1, 4 ones, stuff 0.
        restart_only();
        expect_out("restart idle", K_NONE, 1'b0, 3'd0);
        for (int i = 0; i < 5; i++) begin
            send(1'b0);
            expect_out($sformatf("dyn zero %0d", i), K_DATA, 1'b0, 3'd0);
        end
        send(1'b1);
        expect_out("dyn stuff1", K_STUFF, 1'b0, 3'd1);
        for (int i = 0; i < 4; i++) begin
            send(1'b1);
            expect_out($sformatf("dyn one %0d", i), K_DATA, 1'b1, 3'd1);
        end
        send(1'b0);
        expect_out("dyn stuff2", K_STUFF, 1'b0, 3'd2);

        // Stuff error on the sixth identical bit; the next bit restarts the run at 1.
        restart_only();
        expect_out("restart clears cnt", K_NONE, 1'b0, 3'd0);
        for (int i = 0; i < 5; i++) begin
            send(1'b1);
            expect_out($sformatf("err run %0d", i), K_DATA, 1'b1, 3'd0);
        end
        send(1'b1);
        expect_out("stuff error", K_ERR, 1'b0, 3'd0);
        send(1'b1);
        expect_out("after err", K_DATA, 1'b1, 3'd0);
        for (int i = 0; i < 4; i++) begin
            send(1'b1);
            expect_out($sformatf("post err run %0d", i), K_DATA, 1'b1, 3'd0);
        end
        send(1'b0);
        expect_out("post err stuff", K_STUFF, 1'b0, 3'd1);

        // Fixed mode with last_bit = 0 and stuff count frozen at 1.
        i_Fixed = 1'b1;
        send(1'b1);
        expect_out("fix entry stuff", K_STUFF, 1'b0, 3'd1);
        send(1'b0); expect_out("fix a", K_DATA, 1'b0, 3'd1);
        send(1'b1); expect_out("fix b", K_DATA, 1'b1, 3'd1);
        send(1'b1); expect_out("fix c", K_DATA, 1'b1, 3'd1);
        send(1'b0); expect_out("fix d", K_DATA, 1'b0, 3'd1);
        send(1'b1);
        expect_out("fix period stuff", K_STUFF, 1'b0, 3'd1);
        send(1'b1); expect_out("fix a2", K_DATA, 1'b1, 3'd1);
        send(1'b1); expect_out("fix b2", K_DATA, 1'b1, 3'd1);
        send(1'b0); expect_out("fix c2", K_DATA, 1'b0, 3'd1);
        send(1'b0); expect_out("fix d2", K_DATA, 1'b0, 3'd1);
        send(1'b0);
        expect_out("fix stuff error", K_ERR, 1'b0, 3'd1);
        i_Fixed = 1'b0;

        // Counter wrap: nine dynamic stuff bits in a 3-bit counter.
        restart_only();
        for (int i = 0; i < 5; i++) begin
            send(1'b0);
            expect_out($sformatf("wrap lead %0d", i), K_DATA, 1'b0, 3'd0);
        end
        for (int k = 1; k <= 9; k++) begin
            logic [3:0] kb;
            kb = 4'(k);
            send(kb[0]);
            expect_out($sformatf("wrap stuff %0d", k), K_STUFF, 1'b0, kb[2:0]);
            if (k < 9) begin
                for (int j = 0; j < 4; j++) begin
                    send(kb[0]);
                    expect_out($sformatf("wrap data %0d.%0d", k, j), K_DATA, kb[0], kb[2:0]);
                end
            end
        end
        restart_only();
        expect_out("wrap restart", K_NONE, 1'b0, 3'd0);

        // Bypass: no stuffing checks while disabled.
        i_Enable = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send(1'b0);
            expect_out($sformatf("bypass %0d", i), K_DATA, 1'b0, 3'd0);
        end
        i_Enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(1'b0);
            expect_out($sformatf("enable run %0d", i), K_DATA, 1'b0, 3'd0);
        end
        send(1'b1);
        expect_out("enable stuff", K_STUFF, 1'b0, 3'd1);

        // Restart coincident with a strobe: bit is data, run restarts at 1, cnt cleared.
        i_Restart = 1'b1;
        send(1'b1);
        i_Restart = 1'b0;
        expect_out("restart+strobe", K_DATA, 1'b1, 3'd0);
        for (int i = 0; i < 4; i++) begin
            send(1'b1);
            expect_out($sformatf("restart run %0d", i), K_DATA, 1'b1, 3'd0);
        end
        send(1'b0);
        expect_out("restart run stuff", K_STUFF, 1'b0, 3'd1);

        // Asynchronous reset mid-run with a valid pulse in flight.
        send(1'b0);
        expect_out("pre rst", K_DATA, 1'b0, 3'd1);
        #2;
        i_Rst = 1'b1;
        #1;
        expect_out("async rst", K_NONE, 1'b0, 3'd0);
        chk("async rst bit", 16'(o_Bit), 16'd1);
        #2;
        i_Rst = 1'b0;
        @(posedge i_Clk);
        #1;
        expect_out("post rst idle", K_NONE, 1'b0, 3'd0);
        for (int i = 0; i < 5; i++) begin
            send(1'b0);
            expect_out($sformatf("post rst run %0d", i), K_DATA, 1'b0, 3'd0);
        end
        send(1'b1);
        expect_out("post rst stuff", K_STUFF, 1'b0, 3'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
